// File: rtl/log_fp_pkg.sv
// Shared formats and helpers for the log10 datapath: range reducer, Log2 core
// and the downstream log10 scaler all take their default widths from here.
package log_fp_pkg;

  localparam int DWI_DEF = 16;
  localparam int DWF_DEF = 16;
  localparam int XWI_DEF = 2;
  localparam int XWF_DEF = 23;
  localparam int EW_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_e;

  // Exponent when the leading one already sits just below the sign bit.
  function automatic int exp_bias(input int dwl, input int dwf);
    return dwl - 2 - dwf;
  endfunction

endpackage

// File: rtl/log_range_reducer_if.sv
// Operand/result handshake bundle between the raw-operand source, the range
// reducer and the Log2 core.
interface log_range_reducer_if
  import log_fp_pkg::*;
#(
  parameter int dWI = DWI_DEF,
  parameter int dWF = DWF_DEF,
  parameter int xWI = XWI_DEF,
  parameter int xWF = XWF_DEF,
  parameter int EW  = EW_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic [dWI+dWF-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [xWI+xWF-1:0]   out_mant;
  logic [EW-1:0]        out_exp;
  logic                 out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_err
  );
endinterface

// File: rtl/log_range_reducer.sv
// Iterative normaliser: shifts the raw operand left one bit per cycle until the
// leading one sits under the sign bit, yielding mantissa in [1,2) and exponent.
//
// state | meaning
// IDLE  | ready for an operand
// NORM  | shifting until the leading one reaches bit dWL-2 (or error flagged)
// DONE  | result registered and held until the consumer takes it
module log_range_reducer
  import log_fp_pkg::*;
#(
  parameter int dWI = DWI_DEF,
  parameter int dWF = DWF_DEF,
  parameter int xWI = XWI_DEF,
  parameter int xWF = XWF_DEF,
  parameter int EW  = EW_DEF
) (
  input logic               Clk,
  input logic               Rst,
  log_range_reducer_if.slave bus
);
  localparam int dWL    = dWI + dWF;
  localparam int CW     = $clog2(dWL);
  localparam int MW     = xWF + 1;
  localparam int EXP_LO = -(2 ** (EW - 1));
  localparam int EXP_HI = (2 ** (EW - 1)) - 1;

  if ((-dWF < EXP_LO) || ((dWI - 2) > EXP_HI)) begin : g_ew_check
    $error("log_range_reducer: EW=%0d cannot hold exponent range", EW);
  end

  norm_state_e              state, state_nxt;
  logic [dWL-1:0]           sh;
  logic [CW-1:0]            cnt;
  logic                     err_r;
  logic                     load, shift, finish;
  logic [MW-1:0]            mant_win;
  logic [xWI+xWF-1:0]       mant_d;
  logic [EW-1:0]            exp_d;

  // Narrow operands are left-justified in the mantissa with zero fill below.
  if (dWL - 1 >= MW) begin : g_win_slice
    assign mant_win = sh[dWL-2 -: MW];
  end else begin : g_win_pad
    assign mant_win = {sh[dWL-2:0], {(MW-dWL+1){1'b0}}};
  end

  assign mant_d = (xWI+xWF)'(mant_win);
  assign exp_d  = EW'(exp_bias(dWL, dWF) - int'(cnt));

  always_ff @(posedge Clk) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    load          = 1'b0;
    shift         = 1'b0;
    finish        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = Rst;
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (err_r || sh[dWL-2]) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          shift = 1'b1;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sh           <= '0;
      cnt          <= '0;
      err_r        <= 1'b0;
      bus.out_mant <= '0;
      bus.out_exp  <= '0;
      bus.out_err  <= 1'b0;
    end else begin
      if (load) begin
        sh    <= bus.in_data;
        cnt   <= '0;
        err_r <= (bus.in_data == '0) | bus.in_data[dWL-1];
      end else if (shift) begin
        sh  <= sh << 1;
        cnt <= cnt + CW'(1);
      end
      if (finish) begin
        bus.out_mant <= err_r ? '0 : mant_d;
        bus.out_exp  <= err_r ? '0 : exp_d;
        bus.out_err  <= err_r;
      end
    end
  end

endmodule

// File: tb/tb_log_range_reducer.sv
// Directed bench for log_range_reducer: stimulus pushes hand-computed results
// into a scoreboard; an independent monitor pops and compares on each output.
module tb_log_range_reducer;

  typedef struct {
    logic [31:0] d;
    logic [24:0] m;
    logic [5:0]  e;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [24:0] m;
    logic [5:0]  e;
    logic        err;
    int          lat;
    int          t_acc;
  } exp_t;

  logic Clk;
  logic Rst;
  int   cyc;
  int   checks;
  int   failures;
  bit   seen;
  exp_t sb[$];
  exp_t e_got;
  vec_t vecs[8];

  log_range_reducer_if bus ();

  log_range_reducer dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Present one operand and record the expected result once it is accepted.
  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    @(negedge Clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v.d;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (i > 0) @(negedge Clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) begin
      timeout_fail("accept");
      bus.in_valid = 1'b0;
      return;
    end
    sb.push_back('{m: v.m, e: v.e, err: v.err, lat: v.lat, t_acc: cyc + 1});
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge Clk);
    if (sb.size() > 0) timeout_fail("drain");
  endtask

  // Monitor: latency on first valid cycle, data on the handshake.
  always @(negedge Clk) begin
    if (Rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        if (!seen) begin
          seen = 1'b1;
          checks++;
          failures++;
          $display("FAIL unexpected_output: mant %0h exp %0h err %0b with empty scoreboard",
                   bus.out_mant, bus.out_exp, bus.out_err);
        end
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", 64'(cyc - sb[0].t_acc + 1), 64'(sb[0].lat));
        end
        if (bus.out_ready) begin
          e_got = sb.pop_front();
          chk("out_mant", 64'(bus.out_mant), 64'(e_got.m));
          chk("out_exp", 64'(bus.out_exp), 64'(e_got.e));
          chk("out_err", 64'(bus.out_err), 64'(e_got.err));
          seen = 1'b0;
        end
      end
    end else begin
      seen = 1'b0;
    end
  end

  logic [24:0] hold_m;
  logic [5:0]  hold_e;
  logic        hold_err;
  bit          got;

  initial begin
    cyc          = 0;
    checks       = 0;
    failures     = 0;
    seen         = 1'b0;
    Rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;

    vecs[0] = '{32'h00010000, 25'h0800000, 6'd0,      1'b0, 16};
    vecs[1] = '{32'h7FFFFFFF, 25'h0FFFFFF, 6'd14,     1'b0, 2};
    vecs[2] = '{32'h00000001, 25'h0800000, 6'b110000, 1'b0, 32};
    vecs[3] = '{32'h00018000, 25'h0C00000, 6'd0,      1'b0, 16};
    vecs[4] = '{32'h00000000, 25'h0000000, 6'd0,      1'b1, 2};
    vecs[5] = '{32'h80000000, 25'h0000000, 6'd0,      1'b1, 2};
    vecs[6] = '{32'h40000000, 25'h0800000, 6'd14,     1'b0, 2};
    vecs[7] = '{32'hFFFFFFFF, 25'h0000000, 6'd0,      1'b1, 2};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_mant", 64'(bus.out_mant), 64'(0));
    chk("rst_out_exp", 64'(bus.out_exp), 64'(0));
    chk("rst_out_err", 64'(bus.out_err), 64'(0));
    Rst = 1'b1;
    #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'(1));

    foreach (vecs[i]) begin
      send(vecs[i]);
      drain();
    end

    // Back-pressure: result must hold while out_ready is low.
    bus.out_ready = 1'b0;
    send(vecs[1]);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge Clk);
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) timeout_fail("hold_valid");
    hold_m   = bus.out_mant;
    hold_e   = bus.out_exp;
    hold_err = bus.out_err;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h00010000;
      @(negedge Clk);
      chk("hold_mant", 64'(bus.out_mant), 64'(hold_m));
      chk("hold_exp", 64'(bus.out_exp), 64'(hold_e));
      chk("hold_err", 64'(bus.out_err), 64'(hold_err));
      chk("hold_out_valid", 64'(bus.out_valid), 64'(1));
      chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge Clk);
    chk("post_hs_in_ready", 64'(bus.in_ready), 64'(1));
    chk("post_hs_out_valid", 64'(bus.out_valid), 64'(0));
    drain();

    // Leave a non-zero result registered, then abandon an operand mid-NORM.
    send(vecs[3]);
    drain();
    @(negedge Clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00000001;
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_out_mant", 64'(bus.out_mant), 64'(0));
    chk("mid_rst_out_exp", 64'(bus.out_exp), 64'(0));
    chk("mid_rst_out_err", 64'(bus.out_err), 64'(0));
    Rst = 1'b1;
    #1;
    chk("mid_rst_idle", 64'(bus.in_ready), 64'(1));
    repeat (40) @(negedge Clk);
    send(vecs[0]);
    drain();

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/log_range_reducer.md
Name: log_range_reducer

Overview:
- Front-end range-reduction stage of the log10 datapath; sits directly upstream of the Log2 polynomial core.
- Takes a raw signed fixed-point operand and normalises it to x = m * 2^e, with mantissa m in [1,2) in the Log2 core's Q(xWI).(xWF) input format.
- Emits the signed integer exponent e alongside m, so the downstream stage forms log2(x) = e + log2(m).
- Sequential: iterative one-bit-per-cycle normaliser with valid/ready handshakes on both sides.

Parameters:
- dWI, 16, integer bits of raw input, sign included
- dWF, 16, fraction bits of raw input
- xWI, 2, integer bits of mantissa output, sign included; matches Log2 core input
- xWF, 23, fraction bits of mantissa output
- EW, 6, exponent width, signed two's complement; must hold the range -dWF..(dWI-2)

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset
- in_valid  in  1  raw operand valid
- in_ready  out  1  block can accept an operand
- in_data  in  dWI+dWF  raw operand, signed Q(dWI).(dWF)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_mant  out  xWI+xWF  normalised mantissa, signed Q(xWI).(xWF), value in [1,2)
- out_exp  out  EW  signed exponent e
- out_err  out  1  operand was zero or negative; log undefined

Behaviour:
- Rst: reset Rst, synchronous, active-low.
  - Reset values: state=IDLE, in_ready=0 during reset, out_valid=0, out_mant=0, out_exp=0, out_err=0, shift counter=0.
  - Reset mid-operation abandons the operand; no output is produced for it.
- Let dWL = dWI+dWF. Internal shift register sh[dWL-1:0], shift counter cnt (clog2(dWL) bits).
- FSM states IDLE, NORM, DONE:
  - IDLE: in_ready=1. On in_valid, load sh=in_data, cnt=0, err_r=(in_data==0 | in_data[dWL-1]), go to NORM.
  - NORM: if err_r, go to DONE. Else if sh[dWL-2]==1, go to DONE. Else sh<<=1, cnt++, stay in NORM.
  - DONE: out_valid=1. Outputs are registered on NORM->DONE and held stable until out_valid & out_ready; then go to IDLE.
- in_ready is combinational from state (high only in IDLE). It re-asserts the cycle after the output handshake; no bypass.
- Result, normal case:
  - out_exp = (dWL-2-dWF) - cnt.
  - out_mant = {xWI-1 zeros, sh[dWL-2 -: xWF+1]}.
  - Truncate, never round, so m never reaches 2.0.
  - If dWL-1 < xWF+1, the bits are left-justified with zero fill below.
- Result, error case: out_mant=0, out_exp=0, out_err=1.
- Latency from in_valid&in_ready to out_valid = (dWL-2-p)+2 cycles, where p is the leading-one index.
  - Min 2 cycles (p=dWL-2, or error).
  - Max dWL cycles (p=0).
- Throughput: one operand in flight. in_valid is ignored outside IDLE.
- out_exp width rule: the exponent range must fit EW; this is an elaboration-time check, not a runtime one.

Decomposition:
- Shared package log_fp_pkg holds:
  - format localparams (dWI/dWF/xWI/xWF/EW defaults shared with the Log2 core and the downstream log10 scaler);
  - FSM state encodings IDLE/NORM/DONE;
  - a function computing the exponent bias dWL-2-dWF.
- No sub-module: the normaliser is a single module; a separate LZC is not warranted at one bit per cycle.

Test Plan:
- in_data=32'h00010000 (1.0) -> out_mant=25'h0800000, out_exp=0, out_err=0, out_valid 16 cycles after accept.
- in_data=32'h7FFFFFFF -> out_mant=25'h0FFFFFF, out_exp=14, latency 2.
- in_data=32'h00000001 -> out_mant=25'h0800000, out_exp=-16 (6'b110000), latency 32. in_data=32'h00018000 (1.5) -> out_mant=25'h0C00000, out_exp=0.
- in_data=0 and in_data=32'h80000000 -> out_err=1, out_mant=0, out_exp=0, latency 2.
- Hold out_ready=0 for 5 cycles in DONE:
  - outputs stay bit-stable and in_ready stays 0;
  - a second in_valid is not accepted;
  - after the handshake, in_ready=1 the next cycle.
- Assert Rst=0 for 1 cycle mid-NORM on input 32'h00000001:
  - next cycle state=IDLE, out_valid=0, all outputs 0;
  - a new operand afterwards normalises correctly.
